// File: rtl/md5_stream.sv
// md5_stream: streaming MD5 engine with in-engine padding and length append.
// Chains 512-bit blocks; RPC rounds are unrolled per COMPUTE cycle.
module md5_stream #(
  parameter int RPC    = 1,
  parameter int BCNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PAD, COMPUTE, ADD, OUT
  } state_t;

  localparam logic [127:0] IV =
    128'h67452301_efcdab89_98badcfe_10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  state_t state, state_n;
  logic [31:0]       m [16];
  logic [3:0]        idx;
  logic [BCNT_W-1:0] bcnt;
  logic [5:0]        rnd;
  logic [31:0]       ca, cb, cc, cd;
  logic [31:0]       wa, wb, wc, wd;
  logic              pend80, mark_ok, fin, len_done;
  logic              acc, wr_en;
  logic [31:0]       ld_word, pad_word, wr_word;
  logic [63:0]       bitlen;
  logic [127:0]      rnd_st;

  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    logic [3:0] g;
    unique case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = 4'(i * 6'd5 + 6'd1);
      2'd2:    g = 4'(i * 6'd3 + 6'd5);
      default: g = 4'(i * 6'd7);
    endcase
    return g;
  endfunction

  function automatic logic [127:0] md5_round(
    input logic [127:0] st,
    input logic [5:0]   i,
    input logic [31:0]  mw
  );
    logic [31:0] a, b, c, d, f, t;
    logic [5:0]  sh;
    {a, b, c, d} = st;
    unique case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    t  = a + f + K[i] + mw;
    sh = {1'b0, S[{i[5:4], i[1:0]}]};
    t  = (t << sh) | (t >> (6'd32 - sh));
    return {d, b + t, b, c};
  endfunction

  assign acc    = in_valid & in_ready;
  assign bitlen = 64'(bcnt) << 3;
  assign out_a  = ca;
  assign out_b  = cb;
  assign out_c  = cc;
  assign out_d  = cd;

  // A short final word carries its own 0x80 marker.
  always_comb begin
    ld_word = in_data;
    if (in_last) begin
      unique case (in_bytes)
        3'd0:    ld_word = 32'h0000_0080;
        3'd1:    ld_word = {16'h0, 8'h80, in_data[7:0]};
        3'd2:    ld_word = {8'h0, 8'h80, in_data[15:0]};
        3'd3:    ld_word = {8'h80, in_data[23:0]};
        default: ld_word = in_data;
      endcase
    end
  end

  always_comb begin
    unique case (1'b1)
      pend80:                  pad_word = 32'h0000_0080;
      mark_ok && idx == 4'd14: pad_word = bitlen[31:0];
      mark_ok && idx == 4'd15: pad_word = bitlen[63:32];
      default:                 pad_word = '0;
    endcase
  end

  assign wr_en   = acc || (state == PAD);
  assign wr_word = (state == PAD) ? pad_word : ld_word;

  always_comb begin
    rnd_st = {wa, wb, wc, wd};
    for (int j = 0; j < RPC; j++)
      rnd_st = md5_round(rnd_st, rnd + 6'(j),
                         m[msg_idx(rnd + 6'(j))]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, LOAD:
        if (acc)
          state_n = (idx == 4'd15) ? COMPUTE :
                    (in_last ? PAD : LOAD);
      PAD:
        if (idx == 4'd15) state_n = COMPUTE;
      COMPUTE:
        if (rnd == 6'(64 - RPC)) state_n = ADD;
      ADD:
        state_n = !fin ? LOAD : (len_done ? OUT : PAD);
      OUT:
        if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == LOAD);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (wr_en) m[idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      bcnt     <= '0;
      rnd      <= '0;
      pend80   <= 1'b0;
      mark_ok  <= 1'b0;
      fin      <= 1'b0;
      len_done <= 1'b0;
      {ca, cb, cc, cd} <= IV;
      {wa, wb, wc, wd} <= IV;
    end else begin
      unique case (state)
        IDLE, LOAD: if (acc) begin
          idx  <= idx + 4'd1;
          bcnt <= bcnt + BCNT_W'(in_bytes);
          if (in_last) begin
            fin     <= 1'b1;
            pend80  <= in_bytes[2];
            mark_ok <= !in_bytes[2] && (idx <= 4'd13);
          end
        end
        PAD: begin
          idx <= idx + 4'd1;
          if (pend80) begin
            pend80  <= 1'b0;
            mark_ok <= (idx <= 4'd13);
          end
          if (mark_ok && idx == 4'd15) len_done <= 1'b1;
        end
        COMPUTE: begin
          {wa, wb, wc, wd} <= rnd_st;
          rnd <= rnd + 6'(RPC);
        end
        ADD: begin
          ca <= ca + wa;
          cb <= cb + wb;
          cc <= cc + wc;
          cd <= cd + wd;
          wa <= ca + wa;
          wb <= cb + wb;
          wc <= cc + wc;
          wd <= cd + wd;
          // Any pad-only block after this one carries the length.
          mark_ok <= 1'b1;
        end
        OUT: if (out_ready) begin
          bcnt     <= '0;
          pend80   <= 1'b0;
          mark_ok  <= 1'b0;
          fin      <= 1'b0;
          len_done <= 1'b0;
          {ca, cb, cc, cd} <= IV;
          {wa, wb, wc, wd} <= IV;
        end
        default: ;
      endcase
    end
  end

endmodule
